mem_bus_dma: RTL and testbench
==============================

MEM_BUS_DMA -- requirements
Module: mem_bus_dma

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for mem_din_ready per beat before aborting.
REQ-002 The block SHALL have port clk, input, 1: system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1: one-cycle request to begin a copy; sampled only in IDLE.
REQ-005 The block SHALL have port src_addr, input, 64: source byte address, latched on accepted start.
REQ-006 The block SHALL have port dst_addr, input, 64: destination byte address, latched on accepted start.
REQ-007 The block SHALL have port word_count, input, 16: number of 64-bit words to copy, latched on accepted start.
REQ-008 The block SHALL have port busy, output, 1: high in every state except IDLE.
REQ-009 The block SHALL have port done, output, 1: one-cycle pulse on successful completion.
REQ-010 The block SHALL have port error, output, 1: one-cycle pulse on abort (misalignment or timeout).
REQ-011 The block SHALL have port mem_addr, output, 64: bus byte address.
REQ-012 The block SHALL have port mem_addr_valid, output, 1: bus request valid.
REQ-013 The block SHALL have port mem_dout_write, output, 1: 1 = write beat, 0 = read beat.
REQ-014 The block SHALL have port mem_dout, output, 64: write data.
REQ-015 The block SHALL have port mem_din, input, 64: read data.
REQ-016 The block SHALL have port mem_din_ready, input, 1: responder completes current beat.

Function
REQ-017 The block SHALL act as bus initiator: a beat completes on the rising edge where mem_addr_valid and mem_din_ready are both high.
REQ-018 The block SHALL hold mem_addr, mem_dout_write and mem_dout stable from beat start until completion.
REQ-019 The block SHALL use states IDLE, READ, WRITE, FIN; transitions: IDLE->READ on start; READ->WRITE on completion; WRITE->READ on completion with words remaining; WRITE->FIN on completion of last word; FIN->IDLE unconditionally; READ/WRITE->IDLE on timeout.
REQ-020 The block SHALL assert mem_addr_valid only in READ and WRITE, with mem_dout_write = 0 in READ and 1 in WRITE.
REQ-021 The block SHALL capture mem_din into an internal 64-bit buffer on READ completion and drive that buffer on mem_dout in WRITE.
REQ-022 The block SHALL advance source and destination addresses by 8 after each completed WRITE, wrapping modulo 2^64.
REQ-023 The block SHALL pulse done for exactly one cycle in FIN.
REQ-024 The block SHALL, with word_count = 0 on start, go IDLE->FIN->IDLE with no bus beat and pulse done.
REQ-025 The block SHALL, if src_addr[2:0] or dst_addr[2:0] is nonzero on start, remain IDLE, issue no beat and pulse error the next cycle.
REQ-026 The block SHALL count wait cycles per beat, reset to 0 at beat start; when the count reaches TIMEOUT without completion, drop mem_addr_valid, pulse error and return to IDLE.
REQ-027 The block SHALL ignore start while busy; latched parameters are unaffected.
REQ-028 The block SHALL accept a new start in the cycle after returning to IDLE.
REQ-029 The block SHALL produce a minimum copy rate of one word per 2 cycles when mem_din_ready is held high (mem_din_ready combinationally tied to mem_addr_valid).

Reset
REQ-030 The block SHALL, on rst_n low, immediately enter IDLE with busy, done, error, mem_addr_valid, mem_dout_write = 0 and mem_addr, mem_dout = 0.
REQ-031 The block SHALL, when reset is asserted mid-copy, abandon the transfer without pulsing done or error.

Verification
REQ-032 A bench SHALL check: src 0x1000, dst 0x2000, count 3, ready tied to valid, source words 0xA..0xC -> reads 0x1000/0x1008/0x1010, writes of 0xA/0xB/0xC to 0x2000/0x2008/0x2010, done after 6 beats, busy low after.
REQ-033 A bench SHALL check: ready delayed 3 cycles per beat, count 2 -> addr/data stable during waits, correct data written, no error.
REQ-034 A bench SHALL check: count 0 -> done pulse, mem_addr_valid never high.
REQ-035 A bench SHALL check: src 0x1004 -> error pulse, no beat, busy stays 0.
REQ-036 A bench SHALL check: TIMEOUT 255, ready held low -> error pulse after 255 wait cycles, valid dropped, block returns to IDLE and next start succeeds.
REQ-037 A bench SHALL check: src 0xFFFF_FFFF_FFFF_FFF8, count 2 -> second read at address 0x0, and rst_n asserted mid-copy -> all outputs 0 immediately, no done.

Source files
------------

// File: rtl/mem_bus_dma.sv
// Word-granular memory-to-memory copy engine: alternates one read beat and one write beat per
// 64-bit word on a simple valid/ready bus, with per-beat timeout and alignment checking.
module mem_bus_dma #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] src_addr,
  input  logic [63:0] dst_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] mem_addr,
  output logic        mem_addr_valid,
  output logic        mem_dout_write,
  output logic [63:0] mem_dout,
  input  logic [63:0] mem_din,
  input  logic        mem_din_ready
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StFin} state_e;

  state_e      state_q;
  logic [63:0] src_q;
  logic [63:0] dst_q;
  logic [15:0] left_q;
  logic [31:0] wait_q;

  assign busy = (state_q != StIdle);

  // mem_dout doubles as the word buffer: it is loaded on read completion and held during WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      src_q          <= '0;
      dst_q          <= '0;
      left_q         <= '0;
      wait_q         <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      mem_addr       <= '0;
      mem_addr_valid <= 1'b0;
      mem_dout_write <= 1'b0;
      mem_dout       <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (src_addr[2:0] != 3'd0 || dst_addr[2:0] != 3'd0) begin
              error <= 1'b1;
            end else begin
              src_q  <= src_addr;
              dst_q  <= dst_addr;
              left_q <= word_count;
              if (word_count == 16'd0) begin
                state_q <= StFin;
                done    <= 1'b1;
              end else begin
                state_q        <= StRead;
                mem_addr       <= src_addr;
                mem_addr_valid <= 1'b1;
                mem_dout_write <= 1'b0;
                wait_q         <= '0;
              end
            end
          end
        end
        StRead: begin
          if (mem_din_ready) begin
            state_q        <= StWrite;
            mem_dout       <= mem_din;
            mem_addr       <= dst_q;
            mem_dout_write <= 1'b1;
            wait_q         <= '0;
          end else if (wait_q == 32'(TIMEOUT - 1)) begin
            state_q        <= StIdle;
            mem_addr_valid <= 1'b0;
            mem_dout_write <= 1'b0;
            error          <= 1'b1;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        StWrite: begin
          if (mem_din_ready) begin
            src_q  <= src_q + 64'd8;
            dst_q  <= dst_q + 64'd8;
            left_q <= left_q - 16'd1;
            wait_q <= '0;
            if (left_q == 16'd1) begin
              state_q        <= StFin;
              mem_addr_valid <= 1'b0;
              mem_dout_write <= 1'b0;
              done           <= 1'b1;
            end else begin
              state_q        <= StRead;
              mem_addr       <= src_q + 64'd8;
              mem_dout_write <= 1'b0;
            end
          end else if (wait_q == 32'(TIMEOUT - 1)) begin
            state_q        <= StIdle;
            mem_addr_valid <= 1'b0;
            mem_dout_write <= 1'b0;
            error          <= 1'b1;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_dma.sv
// Scoreboard bench for mem_bus_dma: expected beats/pulses are queued from a word-level copy model,
// and a negedge monitor checks every completed beat, done and error against the queue.
module tb_mem_bus_dma;

  localparam int unsigned TO = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] src_addr, dst_addr;
  logic [15:0] word_count;
  logic        busy, done, error;
  logic [63:0] mem_addr, mem_dout;
  logic        mem_addr_valid, mem_dout_write;
  logic [63:0] mem_din = '0;
  logic        mem_din_ready;

  bit   tie = 1'b1;
  int   delay = 0;
  logic rdy_drv = 1'b0;

  assign mem_din_ready = tie ? mem_addr_valid : rdy_drv;

  mem_bus_dma #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_count(word_count), .busy(busy), .done(done), .error(error), .mem_addr(mem_addr),
    .mem_addr_valid(mem_addr_valid), .mem_dout_write(mem_dout_write), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_din_ready(mem_din_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;  // 0 read, 1 write, 2 done, 3 error
    logic [63:0] addr;
    logic [63:0] data;
  } item_t;

  item_t       sb[$];
  logic [63:0] mem [logic [63:0]];
  int n_cmp = 0, n_bad = 0;
  int done_cnt = 0, last_run = 0, run = 0, age = 0;
  bit busy_seen = 1'b0;

  function automatic logic [63:0] rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[31:0] ^ 32'h5a5a_1234, ~a[63:32]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_item(input int kind, input logic [63:0] a, input logic [63:0] d);
    item_t it;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected event kind %0d addr %h data %h (nothing expected)", kind, a, d);
    end else begin
      it = sb.pop_front();
      if (it.kind != kind || (kind < 2 && it.addr !== a) || (kind == 1 && it.data !== d)) begin
        n_bad++;
        $display("FAIL event: got kind %0d addr %h data %h, expected kind %0d addr %h data %h",
                 kind, a, d, it.kind, it.addr, it.data);
      end
    end
  endtask

  // Word-level model: read each source word, write it to the destination, then done.
  task automatic model_copy(input logic [63:0] s, input logic [63:0] d, input logic [15:0] n);
    if (s[2:0] != 3'd0 || d[2:0] != 3'd0) begin
      sb.push_back('{3, 64'd0, 64'd0});
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        sb.push_back('{0, s + 64'(i) * 64'd8, 64'd0});
        sb.push_back('{1, d + 64'(i) * 64'd8, rd(s + 64'(i) * 64'd8)});
      end
      sb.push_back('{2, 64'd0, 64'd0});
    end
  endtask

  // Monitor and responder
  logic        prev_wait = 1'b0, prev_done = 1'b0, prev_write;
  logic [63:0] prev_addr, prev_dout;
  always @(negedge clk) begin
    logic comp;
    if (!rst_n) begin
      prev_wait = 1'b0;
      prev_done = 1'b0;
      run       = 0;
      age       = 0;
      rdy_drv   = 1'b0;
    end else begin
      if (mem_addr_valid && !mem_dout_write) mem_din = rd(mem_addr);
      rdy_drv = mem_addr_valid && (age >= delay);
      comp    = mem_addr_valid && (tie || rdy_drv);
      if (prev_wait && mem_addr_valid) begin
        chk("hold_addr", mem_addr, prev_addr);
        chk("hold_write", 64'(mem_dout_write), 64'(prev_write));
        chk("hold_dout", mem_dout, prev_dout);
      end
      if (comp) expect_item(mem_dout_write ? 1 : 0, mem_addr, mem_dout);
      prev_wait  = mem_addr_valid && !comp;
      prev_addr  = mem_addr;
      prev_write = mem_dout_write;
      prev_dout  = mem_dout;
      age        = (mem_addr_valid && !comp) ? age + 1 : 0;
      if (mem_addr_valid) begin
        run = comp ? 0 : run + 1;
      end else if (run != 0) begin
        last_run = run;
        run      = 0;
      end
      if (prev_done) chk("busy_after_done", 64'(busy), 64'd0);
      if (done) begin
        expect_item(2, 64'd0, 64'd0);
        done_cnt++;
      end
      if (error) expect_item(3, 64'd0, 64'd0);
      prev_done = done;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic issue(input logic [63:0] s, input logic [63:0] d, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; src_addr = s; dst_addr = d; word_count = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge clk); #1;
      cyc++;
      if (sb.size() == 0 && !busy) break;
      if (cyc >= budget) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wait_idle: still busy=%0b with %0d expected events after %0d cycles",
                 busy, sb.size(), cyc);
        sb.delete();
        break;
      end
    end
  endtask

  initial begin
    int cyc, d0;
    logic [63:0] s, d;
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; word_count = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, error, mem_addr_valid, mem_dout_write, 59'd0}, 64'd0);
    chk("reset_addr", mem_addr, 64'd0);
    chk("reset_dout", mem_dout, 64'd0);
    rst_n = 1'b1;

    // Basic copy, ready tied to valid: one word per two cycles
    mem[64'h1000] = 64'hA; mem[64'h1008] = 64'hB; mem[64'h1010] = 64'hC;
    tie = 1'b1;
    model_copy(64'h1000, 64'h2000, 16'd3);
    issue(64'h1000, 64'h2000, 16'd3);
    wait_idle(100, cyc);
    chk("tied_copy_cycles", 64'(cyc), 64'd8);

    // Delayed ready, addr/data held during waits
    tie = 1'b0; delay = 3;
    model_copy(64'h5000, 64'h6000, 16'd2);
    issue(64'h5000, 64'h6000, 16'd2);
    wait_idle(200, cyc);

    // Zero-length copy
    tie = 1'b1;
    model_copy(64'h1000, 64'h2000, 16'd0);
    issue(64'h1000, 64'h2000, 16'd0);
    wait_idle(20, cyc);

    // Misaligned source
    busy_seen = 1'b0;
    model_copy(64'h1004, 64'h2000, 16'd2);
    issue(64'h1004, 64'h2000, 16'd2);
    wait_idle(20, cyc);
    repeat (3) @(negedge clk);
    chk("misaligned_busy_seen", 64'(busy_seen), 64'd0);

    // Timeout, then a fresh start must succeed
    tie = 1'b0; delay = 100000; last_run = 0;
    sb.push_back('{3, 64'd0, 64'd0});
    issue(64'h3000, 64'h4000, 16'd2);
    wait_idle(600, cyc);
    chk("timeout_valid_cycles", 64'(last_run), 64'(TO));
    chk("timeout_valid_dropped", 64'(mem_addr_valid), 64'd0);
    tie = 1'b1;
    model_copy(64'h3000, 64'h4000, 16'd2);
    issue(64'h3000, 64'h4000, 16'd2);
    wait_idle(100, cyc);

    // Start while busy is ignored
    tie = 1'b0; delay = 2;
    model_copy(64'h7000, 64'h8000, 16'd3);
    issue(64'h7000, 64'h8000, 16'd3);
    repeat (2) @(posedge clk);
    issue(64'h9000, 64'hA000, 16'd5);
    wait_idle(200, cyc);

    // Source address wrap
    tie = 1'b1;
    model_copy(64'hFFFF_FFFF_FFFF_FFF8, 64'h2_0000, 16'd2);
    issue(64'hFFFF_FFFF_FFFF_FFF8, 64'h2_0000, 16'd2);
    wait_idle(100, cyc);

    // Reset mid-copy: outputs clear at once, no done afterwards
    tie = 1'b0; delay = 2;
    model_copy(64'hB000, 64'hC000, 16'd4);
    issue(64'hB000, 64'hC000, 16'd4);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    d0 = done_cnt;
    #1;
    chk("midreset_outputs", {busy, done, error, mem_addr_valid, mem_dout_write, 59'd0}, 64'd0);
    chk("midreset_addr", mem_addr, 64'd0);
    chk("midreset_dout", mem_dout, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midreset_no_done", 64'(done_cnt), 64'(d0));

    // Randomized copies, ready delays and occasional misalignment
    for (int t = 0; t < 12; t++) begin
      s = {$urandom, $urandom};
      d = {$urandom, $urandom};
      s[2:0] = 3'd0; d[2:0] = 3'd0; s[63] = 1'b0; d[63] = 1'b1;
      if ($urandom_range(0, 4) == 0) s[2:0] = 3'($urandom_range(1, 7));
      delay = int'($urandom_range(0, 3));
      model_copy(s, d, 16'($urandom_range(0, 6)));
      issue(s, d, sb.size() == 0 ? 16'd0 : 16'((sb.size() - 1) / 2));
      wait_idle(400, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
